// File: rtl/multicycle_control_pkg.sv
// Shared MIPS constants: ALU op codes, opcode/funct values and control FSM state encoding.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_TRAP     = 4'd15
  } state_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the IR/datapath and the multicycle controller.
interface multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               zr;
  logic               mem_ready;
  logic               mem_read;
  logic               mem_write;
  logic               iord;
  logic               ir_write;
  logic               pc_en;
  logic [1:0]         pc_source;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [3:0]         control_out;
  logic               reg_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               illegal;
  logic [STATE_W-1:0] state;

  modport master (
    input  opcode, funct, zr, mem_ready,
    output mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, control_out, reg_write, reg_dst,
           mem_to_reg, illegal, state
  );

  modport slave (
    output opcode, funct, zr, mem_ready,
    input  mem_read, mem_write, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, control_out, reg_write, reg_dst,
           mem_to_reg, illegal, state
  );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct to ALU op decode; valid_o low for functs the datapath does not implement.
module alu_op_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_op_o = ALU_ADD;
    valid_o  = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_NOR:  alu_op_o = ALU_NOR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM, one instruction step per state; outputs decode from state.
// Define MULTICYCLE_CONTROL_BNE_EN to accept bne (0x05) alongside beq in BRANCH.
module multicycle_control
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int STATE_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master ctl
);

  state_e     state_q, state_d;
  state_e     illegal_next;
  logic [3:0] r_alu_op;
  logic       r_valid;
  logic       br_take;

  alu_op_decode u_alu_op_decode (
    .funct_i  (ctl.funct),
    .alu_op_o (r_alu_op),
    .valid_o  (r_valid)
  );

  assign illegal_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

`ifdef MULTICYCLE_CONTROL_BNE_EN
  assign br_take = (ctl.opcode == OP_BNE) ? ~ctl.zr : ctl.zr;
`else
  assign br_take = ctl.zr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    ctl.mem_read    = 1'b0;
    ctl.mem_write   = 1'b0;
    ctl.iord        = 1'b0;
    ctl.ir_write    = 1'b0;
    ctl.pc_en       = 1'b0;
    ctl.pc_source   = 2'b00;
    ctl.alu_src_a   = 1'b0;
    ctl.alu_src_b   = 2'b00;
    ctl.control_out = ALU_ADD;
    ctl.reg_write   = 1'b0;
    ctl.reg_dst     = 1'b0;
    ctl.mem_to_reg  = 1'b0;
    ctl.illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = ctl.mem_ready;
        ctl.pc_en     = ctl.mem_ready;
        if (ctl.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target into ALUOut while decoding.
        ctl.alu_src_b = 2'b11;
        case (ctl.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IMM_EXEC;
          default:      state_d = illegal_next;
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (ctl.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (ctl.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        ctl.alu_src_a   = 1'b1;
        ctl.control_out = r_alu_op;
        state_d         = r_valid ? S_R_WB : illegal_next;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a   = 1'b1;
        ctl.control_out = ALU_SUB;
        ctl.pc_source   = 2'b01;
        ctl.pc_en       = br_take;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_source = 2'b10;
        ctl.pc_en     = 1'b1;
        state_d       = S_FETCH;
      end
      S_IMM_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = S_IMM_WB;
      end
      S_IMM_WB: begin
        ctl.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: ctl.illegal = 1'b1;
      default: state_d = S_FETCH;
    endcase
    // Reset kills every strobe at once so no write can complete after rst rises.
    if (rst) begin
      ctl.mem_read  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.iord      = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.pc_en     = 1'b0;
      ctl.pc_source = 2'b00;
      ctl.alu_src_a = 1'b0;
      ctl.alu_src_b = 2'b00;
      ctl.control_out = ALU_ADD;
      ctl.reg_write  = 1'b0;
      ctl.reg_dst    = 1'b0;
      ctl.mem_to_reg = 1'b0;
      ctl.illegal    = 1'b0;
    end
  end

  assign ctl.state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state/strobe traces built from cycle rules.
// Honours MULTICYCLE_CONTROL_BNE_EN when deciding how opcode 0x05 behaves.
module tb_multicycle_control;

`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_if #(.STATE_W(4)) bus ();

  multicycle_control #(.ILLEGAL_TRAP(1'b1), .STATE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fmap [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] strobes_obs();
    return {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_en, bus.reg_write, bus.illegal};
  endfunction

  function automatic logic [11:0] sel_obs();
    return {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.control_out,
            bus.pc_source, bus.reg_dst, bus.mem_to_reg};
  endfunction

  // {mem_read, mem_write, ir_write, pc_en, reg_write, illegal}
  function automatic logic [5:0] exp_strobes(int st, bit rdy, bit z, logic [5:0] op);
    bit take;
    take = (BNE_EN && op == 6'h05) ? !z : z;
    case (st)
      0:         return {1'b1, 1'b0, rdy, rdy, 2'b00};
      3:         return 6'b100000;
      5:         return 6'b010000;
      4, 7, 11:  return 6'b000010;
      8:         return {3'b000, take, 2'b00};
      9:         return 6'b000100;
      15:        return 6'b000001;
      default:   return 6'b000000;
    endcase
  endfunction

  // Only the selects that a state actually defines are compared (mask m).
  task automatic exp_sel(input int st, input logic [5:0] fn,
                         output logic [11:0] m, output logic [11:0] v);
    m = 12'h000; v = 12'h000;
    case (st)
      0:     begin m = 12'hFFC; v = {1'b0, 1'b0, 2'b01, 4'd2, 2'b00, 2'b00}; end
      1:     begin m = 12'h7F0; v = {1'b0, 1'b0, 2'b11, 4'd2, 4'b0000}; end
      2, 10: begin m = 12'h7F0; v = {1'b0, 1'b1, 2'b10, 4'd2, 4'b0000}; end
      3, 5:  begin m = 12'h800; v = 12'h800; end
      4:     begin m = 12'h003; v = 12'h001; end
      6: begin
        m = fmap.exists(int'(fn)) ? 12'h7F0 : 12'h700;
        v = {1'b0, 1'b1, 2'b00, (fmap.exists(int'(fn)) ? 4'(fmap[int'(fn)]) : 4'd0), 4'b0000};
      end
      7:     begin m = 12'h003; v = 12'h002; end
      8:     begin m = 12'h7FC; v = {1'b0, 1'b1, 2'b00, 4'd6, 2'b01, 2'b00}; end
      9:     begin m = 12'h00C; v = 12'h008; end
      11:    begin m = 12'h003; v = 12'h000; end
      default: ;
    endcase
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(bus.state), 32'd0);
    check({tag, "_strobes"}, 32'(strobes_obs()), 32'd0);
    check({tag, "_sels"}, 32'(sel_obs()), 32'h020);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1 check_reset(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Expected per-cycle state trace: fw/mw are wait cycles in FETCH and the memory step.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int mw, input int abort_at);
    int  q_st[$];
    bit  q_rdy[$];
    bit  trap;
    bit  zv;
    logic [11:0] m, v;
    trap = 1'b0;
    for (int k = 0; k <= fw; k++) begin q_st.push_back(0); q_rdy.push_back(k == fw); end
    q_st.push_back(1); q_rdy.push_back(1'($urandom));
    if (op == 6'h23 || op == 6'h2B) begin
      q_st.push_back(2); q_rdy.push_back(1'($urandom));
      for (int k = 0; k <= mw; k++) begin
        q_st.push_back(op == 6'h23 ? 3 : 5); q_rdy.push_back(k == mw);
      end
      if (op == 6'h23) begin q_st.push_back(4); q_rdy.push_back(1'($urandom)); end
    end else if (op == 6'h00) begin
      q_st.push_back(6); q_rdy.push_back(1'($urandom));
      if (fmap.exists(int'(fn))) begin q_st.push_back(7); q_rdy.push_back(1'($urandom)); end
      else trap = 1'b1;
    end else if (op == 6'h08) begin
      q_st.push_back(10); q_rdy.push_back(1'($urandom));
      q_st.push_back(11); q_rdy.push_back(1'($urandom));
    end else if (op == 6'h04 || (BNE_EN && op == 6'h05)) begin
      q_st.push_back(8); q_rdy.push_back(1'($urandom));
    end else if (op == 6'h02) begin
      q_st.push_back(9); q_rdy.push_back(1'($urandom));
    end else trap = 1'b1;
    if (trap) repeat (10) begin q_st.push_back(15); q_rdy.push_back(1'($urandom)); end

    bus.opcode = op;
    bus.funct  = fn;
    foreach (q_st[i]) begin
      zv = (q_st[i] == 8) ? z : 1'($urandom);
      bus.mem_ready = q_rdy[i];
      bus.zr = zv;
      @(negedge clk);
      check($sformatf("op%0h_c%0d_state", op, i), 32'(bus.state), 32'(q_st[i]));
      check($sformatf("op%0h_c%0d_strobes", op, i), 32'(strobes_obs()),
            32'(exp_strobes(q_st[i], q_rdy[i], zv, op)));
      exp_sel(q_st[i], fn, m, v);
      if (m != 12'h000)
        check($sformatf("op%0h_c%0d_sels", op, i), 32'(sel_obs() & m), 32'(v));
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 check_reset("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (trap) do_reset("trap_exit");
  endtask

  initial begin
    logic [5:0] ill_ops [4];
    logic [5:0] fns [7];
    logic [5:0] op, fn;
    fmap[32'h20] = 2;  fmap[32'h22] = 6;  fmap[32'h24] = 0;
    fmap[32'h25] = 1;  fmap[32'h27] = 12; fmap[32'h2A] = 7;
    ill_ops = '{6'h3F, 6'h01, 6'h0F, 6'h05};
    fns     = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};

    rst = 1'b1;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zr = 1'b0; bus.mem_ready = 1'b1;
    #1 check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1);   // lw
    run_instr(6'h00, 6'h22, 1'b0, 0, 0, -1);   // sub
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, -1);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, -1);   // beq not taken
    run_instr(6'h00, 6'h20, 1'b0, 3, 0, -1);   // fetch stalls 3 cycles
    run_instr(6'h08, 6'h00, 1'b0, 0, 0, -1);   // addi
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, -1);   // j
    run_instr(6'h2B, 6'h00, 1'b0, 1, 2, -1);   // sw with waits
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, -1);   // lw with read waits
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, -1);   // bne or illegal
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, -1);   // illegal opcode
    run_instr(6'h00, 6'h3F, 1'b0, 0, 0, -1);   // illegal funct
    run_instr(6'h2B, 6'h00, 1'b0, 0, 3, 4);    // sw aborted by reset in MEM_WR
    run_instr(6'h23, 6'h00, 1'b0, 0, 0, -1);   // normal fetch after abort

    for (int n = 0; n < 40; n++) begin
      fn = fns[$urandom_range(0, 6)];
      case ($urandom_range(0, 7))
        0: op = 6'h23;
        1: op = 6'h2B;
        2: op = 6'h00;
        3: op = 6'h08;
        4: op = 6'h04;
        5: op = 6'h02;
        6: op = 6'h05;
        default: op = ill_ops[$urandom_range(0, 3)];
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle MIPS main control FSM.
- It drives the ALU operation code and all datapath enables and mux selects, one instruction step per state.
- It consumes the ALU zero flag to resolve branches.
- It sits between the instruction register (opcode/funct) and the datapath: register file, memory interface, PC and ALU.

Parameters:
- ILLEGAL_TRAP, 1: 1 = an unknown opcode/funct enters TRAP and holds there; 0 = it is treated as a NOP and returns to FETCH.
- STATE_W, 4: width of the state encoding and of the `state` debug output.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits [31:26], taken from the IR.
- funct  in  6  instruction bits [5:0], taken from the IR.
- zr  in  1  ALU zero flag (result == 0).
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the IR.
- pc_en  out  1  load the PC.
- pc_source  out  2  PC input select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- control_out  out  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- illegal  out  1  high while in TRAP.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Reset (async, asserted):
  - state = FETCH (0).
  - Every enable and strobe is forced to 0: mem_read, mem_write, ir_write, pc_en, reg_write, illegal.
  - All selects are 0; control_out = 2.
- Outputs:
  - Decoded combinationally from state.
  - Mealy terms: pc_en and ir_write in FETCH (gated by mem_ready); pc_en in BRANCH (gated by zr).
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, TRAP=15.
- FETCH:
  - Drives mem_read=1, iord=0, src_a=0, src_b=01, control_out=2, pc_source=00.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives src_a=0, src_b=11, control_out=2 (branch target into ALUOut).
  - Next state by opcode: 0x00 → EXEC_R; 0x23 or 0x2B → MEM_ADDR; 0x04 → BRANCH; 0x02 → JUMP; 0x08 → IMM_EXEC.
  - Any other opcode → TRAP if ILLEGAL_TRAP, else FETCH.
- MEM_ADDR: drives src_a=1, src_b=10, control_out=2. Next state: MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD: drives mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: drives reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEM_WR: drives mem_write=1, iord=1. Holds until mem_ready, then FETCH.
- EXEC_R:
  - Drives src_a=1, src_b=00.
  - control_out from funct: 0x20→2, 0x22→6, 0x24→0, 0x25→1, 0x27→12, 0x2A→7.
  - Next state R_WB; an unknown funct goes to TRAP/FETCH per ILLEGAL_TRAP, with reg_write never asserted.
- R_WB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: drives src_a=1, src_b=00, control_out=6, pc_source=01, pc_en=zr. Next state FETCH.
- JUMP: drives pc_source=10, pc_en=1. Next state FETCH.
- IMM_EXEC: drives src_a=1, src_b=10, control_out=2. Next state IMM_WB.
- IMM_WB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- TRAP:
  - illegal=1; all enables and strobes are 0.
  - Only reset exits TRAP.
- Cycle counts with mem_ready tied high:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each wait cycle adds 1 in FETCH, MEM_RD or MEM_WR.
- mem_read/mem_write stay asserted and stable while waiting for mem_ready.
- Reset mid-instruction aborts immediately: no register or memory write completes after rst rises.
- Unused encodings 12–14 go to FETCH on the next clock.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_BNE_EN.
- Defined: opcode 0x05 (bne) → BRANCH; in BRANCH, pc_en = ~zr for bne and zr for beq.
- Undefined: 0x05 is treated as an illegal opcode.

Decomposition:
- Shared package `mips_pkg`: ALU op constants (ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12), opcode and funct constants, state localparams.
- One sub-module, `alu_op_decode`: combinational funct → control_out plus a valid flag, reused by EXEC_R.

Test Plan:
- lw (opcode 0x23), mem_ready=1 → states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1.
- R-type funct 0x22 → control_out=6 in EXEC_R; reg_write with reg_dst=1 next cycle; 4 cycles total.
- beq with zr=1 → pc_en=1, pc_source=01 in BRANCH; with zr=0 → pc_en=0; both return to FETCH.
- FETCH with mem_ready low for 3 cycles → mem_read held; ir_write=pc_en=0 until the 4th cycle.
- opcode 0x3F, ILLEGAL_TRAP=1 → TRAP, illegal=1 held for 10 cycles; rst → FETCH, illegal=0.
- rst pulsed during MEM_WR (sw) → mem_write drops asynchronously; state=0; next fetch proceeds normally.
